response_timer_ctrl: RTL and testbench

Per-character response timer for the Braille trainer, on the controlling side of the 1-second timebase. On a start request it loads a time limit in seconds and holds the 1-second timer in reset until armed, then releases it. It counts the timer's one-second timeout pulses down to expiry, or stops early when the learner answers. It reports remaining and elapsed seconds plus one-cycle expired/answered pulses to the trainer FSM.

---
 rtl/response_timer_ctrl.sv | 121 ++++++++++++
 tb/tb_response_timer_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/response_timer_ctrl.sv
// Response timer for the Braille trainer: arms the 1-second timer,
// counts its timeout pulses down to expiry or stops on an answer.
module response_timer_ctrl #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] limit_s,
   input  logic         answer_valid,
   input  logic         cancel,
   input  logic         timeout_1s,
   output logic         timer_rst,
   output logic         busy,
   output logic [W-1:0] secs_left,
   output logic [W-1:0] elapsed_s,
   output logic         expired,
   output logic         answered
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [W-1:0] ONE  = W'(1);
   localparam logic [W-1:0] ZERO = '0;

   state_t       state_q, state_d;
   logic         timeout_q;
   logic [W-1:0] secs_left_q, secs_left_d;
   logic [W-1:0] elapsed_q, elapsed_d;
   logic         expired_q, expired_d;
   logic         answered_q, answered_d;
   logic         timer_rst_q, timer_rst_d;
   logic         busy_q, busy_d;
   logic         tick;

   assign tick = timeout_1s & ~timeout_q;

   // Next-state, counter updates and registered-output values.
   always_comb begin
      state_d     = state_q;
      secs_left_d = secs_left_q;
      elapsed_d   = elapsed_q;
      expired_d   = 1'b0;
      answered_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               secs_left_d = limit_s;
               elapsed_d   = ZERO;
               if (limit_s == ZERO) begin
                  expired_d = 1'b1;
                  state_d   = DONE;
               end else begin
                  state_d = ARM;
               end
            end
         end
         ARM: begin
            state_d = cancel ? IDLE : RUN;
         end
         RUN: begin
            if (cancel) begin
               state_d = IDLE;
            end else if (answer_valid) begin
               answered_d = 1'b1;
               state_d    = DONE;
            end else if (tick) begin
               secs_left_d = secs_left_q - ONE;
               elapsed_d   = elapsed_q + ONE;
               if (secs_left_q == ONE) begin
                  expired_d = 1'b1;
                  state_d   = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Timer runs only while counting; busy covers arm and run.
      timer_rst_d = (state_d == RUN);
      busy_d      = (state_d == ARM) || (state_d == RUN);
   end

   // State, edge register and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         timeout_q   <= 1'b0;
         secs_left_q <= '0;
         elapsed_q   <= '0;
         expired_q   <= 1'b0;
         answered_q  <= 1'b0;
         timer_rst_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         timeout_q   <= timeout_1s;
         secs_left_q <= secs_left_d;
         elapsed_q   <= elapsed_d;
         expired_q   <= expired_d;
         answered_q  <= answered_d;
         timer_rst_q <= timer_rst_d;
         busy_q      <= busy_d;
      end
   end

   assign timer_rst = timer_rst_q;
   assign busy      = busy_q;
   assign secs_left = secs_left_q;
   assign elapsed_s = elapsed_q;
   assign expired   = expired_q;
   assign answered  = answered_q;

endmodule

// File: tb/tb_response_timer_ctrl.sv
// Bench for response_timer_ctrl: directed plan scenarios with literal
// checks, then random traffic against a window-level reference model.
module tb_response_timer_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [3:0] limit_s = 4'd0;
   logic       answer_valid = 1'b0;
   logic       cancel = 1'b0;
   logic       timeout_1s = 1'b0;
   logic       timer_rst, busy, expired, answered;
   logic [3:0] secs_left, elapsed_s;

   int n_cmp = 0;
   int n_bad = 0;

   response_timer_ctrl #(.W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .limit_s(limit_s),
      .answer_valid(answer_valid), .cancel(cancel),
      .timeout_1s(timeout_1s), .timer_rst(timer_rst), .busy(busy),
      .secs_left(secs_left), .elapsed_s(elapsed_s),
      .expired(expired), .answered(answered)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the window is described by its phase and the
   // seconds still owed; elapsed is always limit minus what is left.
   localparam int P_IDLE = 0, P_ARMED = 1, P_COUNT = 2, P_END = 3;
   int m_phase = P_IDLE;
   int m_lim = 0, m_left = 0, m_el = 0;
   bit m_exp = 0, m_ans = 0, m_prev = 0, m_live = 0;

   always @(posedge clk) begin
      bit t;
      if (!rst) begin
         m_phase = P_IDLE;
         m_lim = 0; m_left = 0; m_el = 0;
         m_exp = 0; m_ans = 0; m_prev = 0;
      end else begin
         t = timeout_1s && !m_prev;
         m_prev = timeout_1s;
         m_exp = 0;
         m_ans = 0;
         if (m_phase == P_IDLE) begin
            if (start) begin
               m_lim = limit_s; m_left = limit_s; m_el = 0;
               if (limit_s == 0) begin
                  m_exp = 1; m_phase = P_END;
               end else m_phase = P_ARMED;
            end
         end else if (m_phase == P_ARMED) begin
            m_phase = cancel ? P_IDLE : P_COUNT;
         end else if (m_phase == P_COUNT) begin
            if (cancel) m_phase = P_IDLE;
            else if (answer_valid) begin
               m_ans = 1; m_phase = P_END;
            end else if (t) begin
               m_left = m_left - 1;
               m_el = m_lim - m_left;
               if (m_left == 0) begin
                  m_exp = 1; m_phase = P_END;
               end
            end
         end else begin
            m_phase = P_IDLE;
         end
      end
      m_live = 1;
   end

   // Cycle-by-cycle compare away from the active edge.
   always @(negedge clk) begin
      if (m_live) begin
         chk("timer_rst", timer_rst, (m_phase == P_COUNT) ? 1 : 0);
         chk("busy", busy,
             (m_phase == P_ARMED || m_phase == P_COUNT) ? 1 : 0);
         chk("secs_left", secs_left, m_left);
         chk("elapsed_s", elapsed_s, m_el);
         chk("expired", expired, m_exp);
         chk("answered", answered, m_ans);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_tick();
      timeout_1s = 1'b1;
      step(1);
      timeout_1s = 1'b0;
   endtask

   task automatic begin_window(input logic [3:0] lim);
      limit_s = lim;
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(1);
   endtask

   initial begin
      // Reset held with start asserted.
      rst = 1'b0;
      start = 1'b1;
      limit_s = 4'd7;
      step(3);
      chk("rst_secs", secs_left, 0);
      chk("rst_elapsed", elapsed_s, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timer_rst", timer_rst, 0);
      chk("rst_pulses", {expired, answered}, 0);
      start = 1'b0;
      rst = 1'b1;
      step(2);

      // Full expiry with three spaced ticks.
      begin_window(4'd3);
      chk("exp_run_timer_rst", timer_rst, 1);
      chk("exp_start_secs", secs_left, 3);
      for (int i = 0; i < 2; i++) begin
         pulse_tick();
         chk("exp_secs_step", secs_left, 2 - i);
         chk("exp_el_step", elapsed_s, i + 1);
         step(9);
      end
      pulse_tick();
      chk("exp_pulse", expired, 1);
      chk("exp_secs0", secs_left, 0);
      chk("exp_el3", elapsed_s, 3);
      step(1);
      chk("exp_pulse_drop", expired, 0);
      chk("exp_busy", busy, 0);
      step(2);

      // Early answer after two ticks.
      begin_window(4'd5);
      pulse_tick(); step(4);
      pulse_tick(); step(4);
      answer_valid = 1'b1;
      step(1);
      answer_valid = 1'b0;
      chk("ans_pulse", answered, 1);
      chk("ans_busy", busy, 0);
      chk("ans_secs", secs_left, 3);
      chk("ans_el", elapsed_s, 2);
      step(2);
      chk("ans_hold_secs", secs_left, 3);
      chk("ans_hold_el", elapsed_s, 2);
      chk("ans_timer_rst", timer_rst, 0);

      // Answer and tick in the same cycle: answer wins.
      begin_window(4'd1);
      answer_valid = 1'b1;
      timeout_1s = 1'b1;
      step(1);
      answer_valid = 1'b0;
      timeout_1s = 1'b0;
      chk("sim_ans", answered, 1);
      chk("sim_exp", expired, 0);
      chk("sim_secs", secs_left, 1);
      chk("sim_el", elapsed_s, 0);
      step(3);

      // Held timeout level counts once.
      begin_window(4'd3);
      timeout_1s = 1'b1;
      step(5);
      timeout_1s = 1'b0;
      step(1);
      chk("held_secs", secs_left, 2);
      chk("held_el", elapsed_s, 1);
      cancel = 1'b1;
      step(1);
      cancel = 1'b0;
      step(2);

      // Zero limit expires immediately without going busy.
      limit_s = 4'd0;
      start = 1'b1;
      step(1);
      start = 1'b0;
      chk("zero_exp", expired, 1);
      chk("zero_busy", busy, 0);
      step(1);
      chk("zero_exp_drop", expired, 0);
      step(2);

      // Cancel in RUN with ignored start.
      begin_window(4'd5);
      pulse_tick(); step(2);
      limit_s = 4'd9;
      start = 1'b1;
      step(1);
      start = 1'b0;
      chk("ign_start_secs", secs_left, 4);
      cancel = 1'b1;
      step(1);
      cancel = 1'b0;
      chk("cancel_busy", busy, 0);
      chk("cancel_pulses", {expired, answered}, 0);
      chk("cancel_secs", secs_left, 4);
      step(3);

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         start        = ($urandom_range(0, 7) == 0);
         limit_s      = 4'($urandom_range(0, 15));
         timeout_1s   = ($urandom_range(0, 3) == 0);
         answer_valid = ($urandom_range(0, 39) == 0);
         cancel       = ($urandom_range(0, 59) == 0);
         rst          = ($urandom_range(0, 499) != 0);
         step(1);
      end
      rst = 1'b1;
      start = 1'b0;
      timeout_1s = 1'b0;
      answer_valid = 1'b0;
      cancel = 1'b0;
      step(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
